bp_me_wormhole_mem_cmd_tx: RTL and testbench



---
 rtl/bp_me_pkg.sv | 37 +++
 rtl/bsg_arb_round_robin.sv | 48 ++++
 rtl/bp_me_wormhole_mem_cmd_tx.sv | 169 ++++++++++++++++
 tb/tb_bp_me_wormhole_mem_cmd_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared memory-command types, wormhole packet macro and length helper
`define DECLARE_BP_MEM_WORMHOLE_PACKET_S(cord_w, cid_w, len_w, msg_w, data_w) \
    typedef struct packed {                       \
        logic [data_w-1:0] data;                  \
        logic [msg_w-1:0]  msg;                   \
        logic [cid_w-1:0]  src_cid;               \
        logic [cord_w-1:0] src_cord;              \
        logic [len_w-1:0]  len;                   \
        logic [cid_w-1:0]  cid;                   \
        logic [cord_w-1:0] cord;                  \
    } bp_mem_wormhole_packet_s

package bp_me_pkg;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'h0,
        e_cce_mem_wr    = 4'h1,
        e_cce_mem_uc_rd = 4'h2,
        e_cce_mem_uc_wr = 4'h3,
        e_cce_mem_wb    = 4'h4
    } bp_cce_mem_cmd_type_e;

    typedef enum logic {
        e_tx_idle,
        e_tx_send
    } tx_state_e;

    // Message header layout, LSB first: msg_type, size (bytes = 2^size), then address/payload.
    localparam int msg_type_width_gp = 4;
    localparam int msg_size_width_gp = 3;
    localparam int num_sizes_gp      = 1 << msg_size_width_gp;

    function automatic int bp_mem_wormhole_len(input int hdr, input int bytes, input int flit);
        return (hdr + 8 * bytes + flit - 1) / flit - 1;
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// rtl/bsg_arb_round_robin.sv - round-robin grant, pointer moves past the winner on each accept
module bsg_arb_round_robin #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] reqs_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] grants_o,
    output logic               v_o
);
    localparam int tag_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [tag_width_lp-1:0] ptr_q, ptr_d;
    logic [tag_width_lp-1:0] win_tag;

    always_comb begin
        int idx;
        int nxt;
        idx      = 0;
        nxt      = 0;
        grants_o = '0;
        win_tag  = '0;
        // Walk backwards so the request closest to the pointer is the one kept.
        for (int k = width_p - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= width_p) idx = idx - width_p;
            if (reqs_i[idx]) begin
                grants_o      = '0;
                grants_o[idx] = 1'b1;
                win_tag       = tag_width_lp'(idx);
            end
        end
        v_o   = |reqs_i;
        ptr_d = ptr_q;
        if (yumi_i && v_o) begin
            nxt = int'(win_tag) + 1;
            if (nxt >= width_p) nxt = 0;
            ptr_d = tag_width_lp'(nxt);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bp_me_wormhole_mem_cmd_tx.sv
// rtl/bp_me_wormhole_mem_cmd_tx.sv - arbitrates memory commands and serializes size-trimmed wormhole packets
module bp_me_wormhole_mem_cmd_tx
    import bp_me_pkg::*;
#(
    parameter int num_chan_p   = 2,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 5,
    parameter int cid_width_p  = 2,
    parameter int len_width_p  = 4,
    parameter int msg_width_p  = 43,
    parameter int data_width_p = 512
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [num_chan_p*(msg_width_p+data_width_p)-1:0] mem_cmd_i,
    input  logic [num_chan_p-1:0]                         mem_cmd_v_i,
    output logic [num_chan_p-1:0]                         mem_cmd_ready_and_o,
    input  logic [cord_width_p-1:0]                       src_cord_i,
    input  logic [cid_width_p-1:0]                        src_cid_i,
    input  logic [num_chan_p*cord_width_p-1:0]            dst_cord_i,
    input  logic [num_chan_p*cid_width_p-1:0]             dst_cid_i,
    output logic [flit_width_p-1:0]                       link_data_o,
    output logic                                          link_v_o,
    input  logic                                          link_ready_and_i,
    output logic                                          err_o
);
    localparam int cmd_width_lp = msg_width_p + data_width_p;
    localparam int hdr_width_lp = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_width_p;
    localparam int pkt_width_lp = hdr_width_lp + data_width_p;
    localparam int num_flits_lp = (pkt_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int buf_width_lp = num_flits_lp * flit_width_p;
    localparam logic [data_width_p-1:0] one_lp = data_width_p'(1);
    localparam logic [len_width_p-1:0]  len_hdr_lp =
        len_width_p'(bp_mem_wormhole_len(hdr_width_lp, 0, flit_width_p));

    `DECLARE_BP_MEM_WORMHOLE_PACKET_S(cord_width_p, cid_width_p, len_width_p, msg_width_p, data_width_p);

    // Per-size constants: flit count, payload mask and whether the size fits the data field.
    logic [num_sizes_gp-1:0][len_width_p-1:0]  len_tbl;
    logic [num_sizes_gp-1:0][data_width_p-1:0] mask_tbl;
    logic [num_sizes_gp-1:0]                   size_ok_tbl;

    for (genvar s = 0; s < num_sizes_gp; s++) begin : g_size
        localparam int bytes_lp = 1 << s;
        localparam int bits_lp  = 8 * bytes_lp;
        localparam int len_lp   = bp_mem_wormhole_len(hdr_width_lp, bytes_lp, flit_width_p);
        assign len_tbl[s]     = len_width_p'(len_lp);
        assign size_ok_tbl[s] = (bits_lp <= data_width_p);
        if (bits_lp >= data_width_p) begin : g_full
            assign mask_tbl[s] = '1;
        end else begin : g_part
            assign mask_tbl[s] = (one_lp << bits_lp) - one_lp;
        end
    end

    logic [num_chan_p-1:0]        grants;
    logic                         win_v;
    logic                         accept_en;
    logic                         accept;
    logic                         last_hs;
    logic [cmd_width_lp-1:0]      win_cmd;
    logic [cord_width_p-1:0]      win_cord;
    logic [cid_width_p-1:0]       win_cid;
    logic [msg_type_width_gp-1:0] win_type;
    logic [msg_size_width_gp-1:0] win_size;
    logic                         has_data;
    logic                         legal;
    logic [len_width_p-1:0]       len_sel;
    logic [data_width_p-1:0]      data_m;
    bp_mem_wormhole_packet_s      pkt_n;

    tx_state_e                    state_q, state_d;
    logic [buf_width_lp-1:0]      pkt_q, pkt_d;
    logic [len_width_p-1:0]       len_q, len_d;
    logic [len_width_p-1:0]       cnt_q, cnt_d;
    logic                         err_q, err_d;

    bsg_arb_round_robin #(
        .width_p (num_chan_p)
    ) arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .reqs_i    (mem_cmd_v_i),
        .yumi_i    (accept),
        .grants_o  (grants),
        .v_o       (win_v)
    );

    always_comb begin
        win_cmd  = '0;
        win_cord = '0;
        win_cid  = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (grants[i]) begin
                win_cmd  = mem_cmd_i[i*cmd_width_lp +: cmd_width_lp];
                win_cord = dst_cord_i[i*cord_width_p +: cord_width_p];
                win_cid  = dst_cid_i[i*cid_width_p +: cid_width_p];
            end
        end
    end

    always_comb begin
        win_type = win_cmd[msg_type_width_gp-1:0];
        win_size = win_cmd[msg_type_width_gp +: msg_size_width_gp];
        has_data = (win_type == e_cce_mem_uc_wr) || (win_type == e_cce_mem_wb);
        legal    = (win_type == e_cce_mem_rd) || (win_type == e_cce_mem_wr)
                || (win_type == e_cce_mem_uc_rd) || (has_data && size_ok_tbl[win_size]);
        len_sel  = has_data ? len_tbl[win_size] : len_hdr_lp;
        data_m   = has_data ? (win_cmd[msg_width_p +: data_width_p] & mask_tbl[win_size]) : '0;

        pkt_n.data     = data_m;
        pkt_n.msg      = win_cmd[msg_width_p-1:0];
        pkt_n.src_cid  = src_cid_i;
        pkt_n.src_cord = src_cord_i;
        pkt_n.len      = len_sel;
        pkt_n.cid      = win_cid;
        pkt_n.cord     = win_cord;
    end

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        last_hs   = (state_q == e_tx_send) && link_ready_and_i && (cnt_q == len_q);
        // A new command can only land while idle or on the final flit handshake.
        accept_en = reset_n_i && ((state_q == e_tx_idle) || last_hs);
        accept    = accept_en && win_v;

        if ((state_q == e_tx_send) && link_ready_and_i) begin
            cnt_d = cnt_q + len_width_p'(1);
            if (last_hs) state_d = e_tx_idle;
        end

        if (accept) begin
            if (legal) begin
                state_d = e_tx_send;
                pkt_d   = buf_width_lp'(pkt_n);
                len_d   = len_sel;
                cnt_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_tx_idle;
            pkt_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_cmd_ready_and_o = grants & {num_chan_p{accept_en}};
    assign link_v_o            = (state_q == e_tx_send);
    assign link_data_o         = link_v_o ? pkt_q[cnt_q*flit_width_p +: flit_width_p] : '0;
    assign err_o               = err_q;

endmodule

// File: tb/tb_bp_me_wormhole_mem_cmd_tx.sv
// tb/tb_bp_me_wormhole_mem_cmd_tx.sv - directed self-checking bench for the memory command transmitter
module tb_bp_me_wormhole_mem_cmd_tx;
    localparam int N  = 2;
    localparam int F  = 64;
    localparam int CW = 5;
    localparam int IW = 2;
    localparam int LW = 4;
    localparam int M  = 43;
    localparam int D  = 512;
    localparam int C  = M + D;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N*C-1:0]    mem_cmd;
    logic [N-1:0]      v;
    logic [N-1:0]      rdy;
    logic [CW-1:0]     src_cord;
    logic [IW-1:0]     src_cid;
    logic [N*CW-1:0]   dst_cord;
    logic [N*IW-1:0]   dst_cid;
    logic [F-1:0]      ldata;
    logic              lv;
    logic              lready;
    logic              err;

    logic [C-1:0]      c0, c1;
    logic [575:0]      p, q, p0, p1;
    logic [D-1:0]      dat;
    logic [1:0]        er;
    logic [63:0]       ed;
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign mem_cmd  = {c1, c0};
    assign src_cord = 5'h0A;
    assign src_cid  = 2'h1;
    assign dst_cord = {5'h11, 5'h03};
    assign dst_cid  = {2'h3, 2'h2};

    bp_me_wormhole_mem_cmd_tx #(
        .num_chan_p(N), .flit_width_p(F), .cord_width_p(CW), .cid_width_p(IW),
        .len_width_p(LW), .msg_width_p(M), .data_width_p(D)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .mem_cmd_i           (mem_cmd),
        .mem_cmd_v_i         (v),
        .mem_cmd_ready_and_o (rdy),
        .src_cord_i          (src_cord),
        .src_cid_i           (src_cid),
        .dst_cord_i          (dst_cord),
        .dst_cid_i           (dst_cid),
        .link_data_o         (ldata),
        .link_v_o            (lv),
        .link_ready_and_i    (lready),
        .err_o               (err)
    );

    function automatic logic [M-1:0] mk_msg(input logic [3:0] t, input logic [2:0] sz, input logic [35:0] addr);
        return {addr, sz, t};
    endfunction

    function automatic logic [C-1:0] mk_cmd(input logic [3:0] t, input logic [2:0] sz,
                                            input logic [35:0] addr, input logic [D-1:0] data);
        return {data, mk_msg(t, sz, addr)};
    endfunction

    // Packet as the link should carry it: {pad, data, msg, src_cid, src_cord, len, cid, cord}.
    function automatic logic [575:0] exp_pkt(input logic [D-1:0] dm, input logic [M-1:0] msg,
                                             input logic [3:0] len, input int ch);
        logic [4:0] dc;
        logic [1:0] di;
        dc = (ch == 1) ? 5'h11 : 5'h03;
        di = (ch == 1) ? 2'h3 : 2'h2;
        return {3'b000, dm, msg, 2'h1, 5'h0A, len, di, dc};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        v       = '0;
        c0      = '0;
        c1      = '0;
        lready  = 1'b0;
        tick();
        tick();
        // Reset values, even with commands pending.
        v  = 2'b11;
        c0 = mk_cmd(4'h0, 3'd0, 36'h10, '0);
        #1;
        check("rst_rdy", 64'(rdy), 64'h0);
        check("rst_lv", 64'(lv), 64'h0);
        check("rst_data", ldata, 64'h0);
        check("rst_err", 64'(err), 64'h0);
        v       = '0;
        reset_n = 1'b1;
        tick();

        // 1: single read, one flit, garbage data must not appear.
        c0     = mk_cmd(4'h0, 3'd0, 36'h40, '1);
        v      = 2'b01;
        lready = 1'b1;
        #1;
        check("t1_rdy", 64'(rdy), 64'h1);
        tick();
        v = '0;
        #1;
        p = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h40), 4'd0, 0);
        check("t1_lv", 64'(lv), 64'h1);
        check("t1_flit0", ldata, p[63:0]);
        check("t1_pad", 64'(ldata[63:61]), 64'h0);
        check("t1_rdy_send", 64'(rdy), 64'h0);
        tick();
        check("t1_lv_end", 64'(lv), 64'h0);

        // 2: uc write of 8 bytes, two flits, upper data bits masked.
        dat = {{448{1'b1}}, 64'h1122334455667788};
        c0  = mk_cmd(4'h3, 3'd3, 36'h80, dat);
        v   = 2'b01;
        #1;
        check("t2_rdy", 64'(rdy), 64'h1);
        tick();
        v = '0;
        #1;
        p = exp_pkt({448'b0, 64'h1122334455667788}, mk_msg(4'h3, 3'd3, 36'h80), 4'd1, 0);
        check("t2_flit0", ldata, p[63:0]);
        tick();
        check("t2_lv1", 64'(lv), 64'h1);
        check("t2_flit1", ldata, 64'h022446688AACCEF1);
        tick();
        check("t2_lv_end", 64'(lv), 64'h0);

        // 3: 64-byte writeback with backpressure; a queued read is taken only on the last handshake.
        for (int i = 0; i < 16; i++) dat[i*32 +: 32] = 32'hC0DE0000 + i;
        c0 = mk_cmd(4'h4, 3'd6, 36'h1000, dat);
        v  = 2'b01;
        #1;
        check("t3_rdy", 64'(rdy), 64'h1);
        p = exp_pkt(dat, mk_msg(4'h4, 3'd6, 36'h1000), 4'd8, 0);
        tick();
        c0 = mk_cmd(4'h0, 3'd0, 36'h2000, '0);
        #1;
        check("t3_flit0", ldata, p[63:0]);
        check("t3_rdy0", 64'(rdy), 64'h0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            lready = 1'b0;
            #1;
            check($sformatf("t3_stall_lv%0d", k), 64'(lv), 64'h1);
            check($sformatf("t3_stall_flit%0d", k), ldata, p[k*64 +: 64]);
            check($sformatf("t3_stall_rdy%0d", k), 64'(rdy), 64'h0);
            tick();
            lready = 1'b1;
            #1;
            check($sformatf("t3_flit%0d", k), ldata, p[k*64 +: 64]);
            check($sformatf("t3_rdy%0d", k), 64'(rdy), (k == 8) ? 64'h1 : 64'h0);
            tick();
        end
        v = '0;
        #1;
        q = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h2000), 4'd0, 0);
        check("t3_b2b_lv", 64'(lv), 64'h1);
        check("t3_b2b_flit", ldata, q[63:0]);
        tick();
        check("t3_lv_end", 64'(lv), 64'h0);

        // 4: both channels streaming reads from a fresh pointer.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        c0 = mk_cmd(4'h0, 3'd0, 36'h300, '0);
        c1 = mk_cmd(4'h0, 3'd0, 36'h304, '0);
        p0 = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h300), 4'd0, 0);
        p1 = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h304), 4'd0, 1);
        v  = 2'b11;
        #1;
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) begin
                v = '0;
                #1;
            end
            er = (c == 8) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t4_rdy%0d", c), 64'(rdy), 64'(er));
            check($sformatf("t4_lv%0d", c), 64'(lv), (c > 0) ? 64'h1 : 64'h0);
            if (c > 0) begin
                ed = ((c - 1) % 2 == 0) ? p0[63:0] : p1[63:0];
                check($sformatf("t4_flit%0d", c), ldata, ed);
            end
            tick();
        end
        check("t4_lv_end", 64'(lv), 64'h0);

        // 5: undefined type on ch1 is dropped with an error pulse, then a read on ch1 goes out.
        c1 = mk_cmd(4'hF, 3'd0, 36'h500, '1);
        v  = 2'b10;
        #1;
        check("t5_rdy_bad", 64'(rdy), 64'h2);
        check("t5_err0", 64'(err), 64'h0);
        tick();
        check("t5_err1", 64'(err), 64'h1);
        check("t5_lv_bad", 64'(lv), 64'h0);
        c1 = mk_cmd(4'h0, 3'd0, 36'h504, '1);
        #1;
        check("t5_rdy_rd", 64'(rdy), 64'h2);
        tick();
        v = '0;
        #1;
        q = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h504), 4'd0, 1);
        check("t5_err_clr", 64'(err), 64'h0);
        check("t5_lv", 64'(lv), 64'h1);
        check("t5_flit", ldata, q[63:0]);
        tick();
        check("t5_lv_end", 64'(lv), 64'h0);

        // 5b: payload larger than the data field is illegal.
        c0 = mk_cmd(4'h3, 3'd7, 36'h600, '1);
        v  = 2'b01;
        #1;
        check("t5b_rdy", 64'(rdy), 64'h1);
        tick();
        v = '0;
        #1;
        check("t5b_err", 64'(err), 64'h1);
        check("t5b_lv", 64'(lv), 64'h0);
        tick();
        check("t5b_err_clr", 64'(err), 64'h0);

        // 5c: illegal ch0 and legal ch1 together; pointer sits at ch1.
        c0 = mk_cmd(4'h7, 3'd0, 36'h700, '0);
        c1 = mk_cmd(4'h0, 3'd0, 36'h704, '0);
        v  = 2'b11;
        #1;
        check("t5c_rdy_ch1", 64'(rdy), 64'h2);
        tick();
        q = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h704), 4'd0, 1);
        check("t5c_flit", ldata, q[63:0]);
        check("t5c_rdy_ch0", 64'(rdy), 64'h1);
        tick();
        v = '0;
        #1;
        check("t5c_err", 64'(err), 64'h1);
        check("t5c_lv", 64'(lv), 64'h0);
        tick();
        check("t5c_err_clr", 64'(err), 64'h0);

        // 6: reset in the middle of a writeback.
        c0 = mk_cmd(4'h4, 3'd6, 36'h1000, dat);
        v  = 2'b01;
        #1;
        tick();
        v = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_flit%0d", k), ldata, p[k*64 +: 64]);
            tick();
        end
        check("t6_flit4", ldata, p[4*64 +: 64]);
        reset_n = 1'b0;
        #1;
        check("t6_lv_rst", 64'(lv), 64'h0);
        check("t6_data_rst", ldata, 64'h0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_idle_lv%0d", k), 64'(lv), 64'h0);
        end
        c0 = mk_cmd(4'h0, 3'd0, 36'h800, '0);
        v  = 2'b01;
        #1;
        check("t6_rdy", 64'(rdy), 64'h1);
        tick();
        v = '0;
        #1;
        q = exp_pkt('0, mk_msg(4'h0, 3'd0, 36'h800), 4'd0, 0);
        check("t6_lv", 64'(lv), 64'h1);
        check("t6_flit", ldata, q[63:0]);
        tick();
        check("t6_lv_end", 64'(lv), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
